// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : UART data width and bit/character timing shared by the rx path
// Revision : 1.0
// ============================================================================
package uart_pkg;
  localparam int UART_DATA_W            = 8;
  localparam int CLKS_PER_BIT           = 10;
  localparam int CHAR_CLKS              = 10 * CLKS_PER_BIT;
  localparam int DEFAULT_TIMEOUT_CYCLES = 4 * CHAR_CLKS;
endpackage
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// uart_fifo_mem : DEPTH x DATA_W register array, one write port, async read
// Revision      : 1.0
// ============================================================================
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Entries are reset so the head byte reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// uart_rx_fifo : FWFT byte buffer behind uart_rx with level, overrun, timeout
// Revision     : 1.0
// ============================================================================
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int DATA_W         = UART_DATA_W,
  parameter int AF_THRESH      = 12,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [DATA_W-1:0]      rx_data_i,
  input  logic                   rx_done_tick_i,
  input  logic                   rx_active_i,
  output logic [DATA_W-1:0]      m_data_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  input  logic                   flush_i,
  input  logic                   clr_ovr_i,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   almost_full_o,
  output logic                   overrun_o,
  output logic                   rx_timeout_o
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_LW-1:0] c_FULL   = c_LW'(DEPTH);
  localparam logic [c_LW-1:0] c_AF     = c_LW'(AF_THRESH);
  localparam logic [c_TW-1:0] c_TO_MAX = c_TW'(TIMEOUT_CYCLES);

  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_LW-1:0] r_level;
  logic            r_overrun;
  logic [c_TW-1:0] r_idle_cnt;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_idle_clr;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_FULL);
  // A pop frees the slot the same-cycle push writes into, so full+pop still accepts.
  assign w_pop      = m_ready_i && !w_empty && !flush_i;
  assign w_push     = rx_done_tick_i && (!w_full || w_pop) && !flush_i;
  assign w_drop     = rx_done_tick_i && !w_push && !flush_i;
  assign w_idle_clr = w_push || w_pop || rx_active_i || w_empty || flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overrun  <= 1'b0;
      r_idle_cnt <= '0;
    end else if (flush_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overrun  <= 1'b0;
      r_idle_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
      // A drop in the clearing cycle keeps the flag set.
      if (w_drop)         r_overrun <= 1'b1;
      else if (clr_ovr_i) r_overrun <= 1'b0;
      if (w_idle_clr)                 r_idle_cnt <= '0;
      else if (r_idle_cnt != c_TO_MAX) r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .we_i    (w_push),
    .waddr_i (r_wr_ptr),
    .wdata_i (rx_data_i),
    .raddr_i (r_rd_ptr),
    .rdata_o (m_data_o)
  );

  assign m_valid_o     = !w_empty;
  assign level_o       = r_level;
  assign almost_full_o = (r_level >= c_AF);
  assign overrun_o     = r_overrun;
  assign rx_timeout_o  = (r_idle_cnt == c_TO_MAX);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_fifo : directed scenarios plus randomized traffic vs queue model
// Revision        : 1.0
// ============================================================================
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int TO    = 400;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic [7:0] rx_data_i = '0;
  logic       rx_done_tick_i = 1'b0;
  logic       rx_active_i = 1'b0;
  logic [7:0] m_data_o;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       clr_ovr_i = 1'b0;
  logic [4:0] level_o;
  logic       almost_full_o;
  logic       overrun_o;
  logic       rx_timeout_o;

  int checks = 0;
  int failures = 0;

  // Reference model: byte queue, sticky drop flag, idle-cycle count.
  logic [7:0] q[$];
  bit         m_ovr;
  int         m_idle;

  always #5 clk_i = ~clk_i;

  uart_rx_fifo #(
    .DEPTH(DEPTH), .DATA_W(8), .AF_THRESH(AF), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .rx_data_i(rx_data_i),
    .rx_done_tick_i(rx_done_tick_i), .rx_active_i(rx_active_i),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .flush_i(flush_i), .clr_ovr_i(clr_ovr_i), .level_o(level_o),
    .almost_full_o(almost_full_o), .overrun_o(overrun_o),
    .rx_timeout_o(rx_timeout_o)
  );

  task automatic mdl_reset();
    q.delete();
    m_ovr  = 1'b0;
    m_idle = 0;
  endtask

  // Advance the model by the current inputs, then one clock; returns 1ns after the edge.
  task automatic cycle();
    bit was_empty, do_pop, do_push;
    was_empty = (q.size() == 0);
    if (flush_i) begin
      mdl_reset();
    end else begin
      do_pop  = !was_empty && m_ready_i;
      do_push = rx_done_tick_i && (q.size() < DEPTH || do_pop);
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(rx_data_i);
      if (rx_done_tick_i && !do_push) m_ovr = 1'b1;
      else if (clr_ovr_i)             m_ovr = 1'b0;
      if (do_pop || do_push || rx_active_i || was_empty) m_idle = 0;
      else if (m_idle < TO)                              m_idle++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data_i = b;
    rx_done_tick_i = 1'b1;
    cycle();
    rx_done_tick_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    mdl_reset();
    checks++; if (level_o !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level_o); end
    checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", m_valid_o); end
    checks++; if (m_data_o !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", m_data_o); end
    checks++; if ({almost_full_o, overrun_o, rx_timeout_o} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {almost_full_o, overrun_o, rx_timeout_o});
    end
    rstn_i = 1'b1;
    cycle();
  endtask

  task automatic test_push_pop();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hAB; exp[2] = 8'hFD;
    for (int i = 0; i < 3; i++) push(exp[i]);
    checks++; if (level_o !== 5'd3) begin failures++; $display("FAIL pp_level got=%0d exp=3", level_o); end
    checks++; if (m_valid_o !== 1'b1) begin failures++; $display("FAIL pp_valid got=%b exp=1", m_valid_o); end
    m_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (m_data_o !== exp[i]) begin failures++; $display("FAIL pp_read%0d got=%h exp=%h", i, m_data_o, exp[i]); end
      cycle();
    end
    m_ready_i = 1'b0;
    checks++; if (m_valid_o !== 1'b0 || level_o !== 5'd0) begin
      failures++; $display("FAIL pp_drained got valid=%b level=%0d exp valid=0 level=0", m_valid_o, level_o);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) begin
      push(8'h10 + 8'(i));
      checks++; if (almost_full_o !== 1'((i + 1) >= AF)) begin
        failures++; $display("FAIL ovr_af level=%0d got=%b exp=%b", i + 1, almost_full_o, (i + 1) >= AF);
      end
    end
    checks++; if (level_o !== 5'd16) begin failures++; $display("FAIL ovr_full_level got=%0d exp=16", level_o); end
    push(8'h55);
    checks++; if (overrun_o !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b exp=1", overrun_o); end
    checks++; if (level_o !== 5'd16) begin failures++; $display("FAIL ovr_level got=%0d exp=16", level_o); end
    checks++; if (m_data_o !== 8'h10) begin failures++; $display("FAIL ovr_head got=%h exp=10", m_data_o); end
    clr_ovr_i = 1'b1;
    cycle();
    clr_ovr_i = 1'b0;
    checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", overrun_o); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    m_ready_i = 1'b1;
    push(8'h77);
    m_ready_i = 1'b0;
    checks++; if (level_o !== 5'd16) begin failures++; $display("FAIL fpp_level got=%0d exp=16", level_o); end
    checks++; if (overrun_o !== 1'b0) begin failures++; $display("FAIL fpp_ovr got=%b exp=0", overrun_o); end
    m_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i < 15) ? 8'h11 + 8'(i) : 8'h77;
      checks++; if (m_data_o !== exp) begin failures++; $display("FAIL fpp_read%0d got=%h exp=%h", i, m_data_o, exp); end
      cycle();
    end
    m_ready_i = 1'b0;
    checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL fpp_empty got=%b exp=0", m_valid_o); end
  endtask

  task automatic test_timeout();
    push(8'h42);
    for (int k = 1; k <= TO; k++) begin
      cycle();
      checks++; if (rx_timeout_o !== 1'(k == TO)) begin
        failures++; $display("FAIL to_rise cycle=%0d got=%b exp=%b", k, rx_timeout_o, k == TO);
      end
    end
    rx_active_i = 1'b1;
    cycle();
    rx_active_i = 1'b0;
    checks++; if (rx_timeout_o !== 1'b0) begin failures++; $display("FAIL to_active_clear got=%b exp=0", rx_timeout_o); end
    m_ready_i = 1'b1;
    cycle();
    m_ready_i = 1'b0;
    repeat (TO + 50) cycle();
    checks++; if (rx_timeout_o !== 1'b0 || m_valid_o !== 1'b0) begin
      failures++; $display("FAIL to_empty got timeout=%b valid=%b exp 0 0", rx_timeout_o, m_valid_o);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push(8'($urandom));
    flush_i = 1'b1;
    rx_data_i = 8'h99;
    rx_done_tick_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    rx_done_tick_i = 1'b0;
    checks++; if (level_o !== 5'd0 || m_valid_o !== 1'b0) begin
      failures++; $display("FAIL flush got level=%0d valid=%b exp 0 0", level_o, m_valid_o);
    end
    repeat (3) cycle();
    checks++; if (m_valid_o !== 1'b0) begin failures++; $display("FAIL flush_hold got=%b exp=0", m_valid_o); end
    push(8'h5A);
    checks++; if (m_data_o !== 8'h5A || level_o !== 5'd1) begin
      failures++; $display("FAIL flush_next got data=%h level=%0d exp 5a 1", m_data_o, level_o);
    end
    m_ready_i = 1'b1;
    cycle();
    m_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) push(8'($urandom_range(1, 255)));
    @(negedge clk_i);
    #2;
    rstn_i = 1'b0;
    #1;
    mdl_reset();
    checks++; if ({m_valid_o, level_o, m_data_o, almost_full_o, overrun_o, rx_timeout_o} !== '0) begin
      failures++; $display("FAIL arst got valid=%b level=%0d data=%h exp all 0", m_valid_o, level_o, m_data_o);
    end
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    push(8'h3C);
    checks++; if (m_data_o !== 8'h3C || level_o !== 5'd1 || m_valid_o !== 1'b1) begin
      failures++; $display("FAIL arst_push got data=%h level=%0d valid=%b exp 3c 1 1", m_data_o, level_o, m_valid_o);
    end
    m_ready_i = 1'b1;
    cycle();
    m_ready_i = 1'b0;
  endtask

  task automatic test_random();
    int rd_pct;
    for (int n = 0; n < 800; n++) begin
      rd_pct = ((n / 100) % 2 == 0) ? 20 : 85;
      rx_data_i      = 8'($urandom);
      rx_done_tick_i = ($urandom_range(0, 99) < 55);
      m_ready_i      = ($urandom_range(0, 99) < rd_pct);
      rx_active_i    = ($urandom_range(0, 7) == 0);
      clr_ovr_i      = ($urandom_range(0, 15) == 0);
      flush_i        = ($urandom_range(0, 99) == 0);
      cycle();
      checks++; if (level_o !== 5'(q.size())) begin failures++; $display("FAIL rnd_level n=%0d got=%0d exp=%0d", n, level_o, q.size()); end
      checks++; if (m_valid_o !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, m_valid_o, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if (m_data_o !== q[0]) begin failures++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, m_data_o, q[0]); end
      end
      checks++; if (almost_full_o !== (q.size() >= AF)) begin failures++; $display("FAIL rnd_af n=%0d got=%b exp=%b", n, almost_full_o, q.size() >= AF); end
      checks++; if (overrun_o !== m_ovr) begin failures++; $display("FAIL rnd_ovr n=%0d got=%b exp=%b", n, overrun_o, m_ovr); end
      checks++; if (rx_timeout_o !== (m_idle == TO)) begin failures++; $display("FAIL rnd_to n=%0d got=%b exp=%b", n, rx_timeout_o, m_idle == TO); end
    end
    {rx_done_tick_i, m_ready_i, rx_active_i, clr_ovr_i, flush_i} = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_push_pop();
    test_overrun();
    test_full_push_pop();
    test_timeout();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
